// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with valid/ready byte input and registered, glitch-free tx.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d, ready_q, busy_q, done_q, done_d;
    logic                 bit_end, last_data, last_stop;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign bit_end   = baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1);
    assign last_data = bit_cnt_q == BIT_W'(DATA_BITS - 1);
    assign last_stop = bit_cnt_q == BIT_W'(STOP_BITS - 1);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = (state_q == IDLE) ? '0 : (bit_end ? '0 : baud_cnt_q + 1'b1);
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: if (tx_valid && ready_q) begin
                state_d   = START;
                bit_cnt_d = '0;
                shreg_d   = tx_data;
`ifdef UART_TX_PARITY_EN
                par_d     = ^tx_data;
`endif
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                state_d   = last_data ? PARITY : DATA;
`else
                state_d   = last_data ? STOP : DATA;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) begin
                // bit_cnt doubles as the stop-bit counter
                bit_cnt_d = last_stop ? '0 : bit_cnt_q + 1'b1;
                state_d   = last_stop ? IDLE : STOP;
                done_d    = last_stop;
            end
            default: state_d = IDLE;
        endcase
        // tx is derived from the next state so the line changes on the same edge as the FSM
`ifdef UART_TX_PARITY_EN
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            ready_q    <= state_d == IDLE;
            busy_q     <= state_d != IDLE;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
endmodule
